regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (RegWrite/Rd/Write_data) between two writeback requesters: req0 = ALU, req1 = load unit.
- Keeps a per-register pending-write scoreboard so the issue stage can detect RAW hazards on Rs1/Rs2 before reading.
- Sits between the execute/memory stages and the register file; its write outputs drive the register file's write port directly.

---
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   requesters (req0 = ALU, req1 = load unit) and tracks a per-register
//   pending-write count so the issue stage can detect RAW hazards.
//
//   Optional feature macro: WB_BYPASS_EN
//     When defined, a source register whose only outstanding write is being
//     committed this cycle is forwarded from rf_wdata instead of stalling.
//     When undefined, fwd outputs are tied to zero.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req0_valid/rd/data, req0_ready   ALU writeback request / accept
//   req1_valid/rd/data, req1_ready   load writeback request / accept
//   alloc_valid/rd, alloc_ready      destination reservation from issue
//   rs1, rs2                         issue-stage source registers
//   stall                            RAW hazard on rs1 or rs2
//   fwd1_valid/data, fwd2_valid/data bypass data for rs1 / rs2
//   rf_we, rf_rd, rf_wdata           register file write port
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall,
    output logic              fwd1_valid,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_valid,
    output logic [DATA_W-1:0] fwd2_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cnt [NREG];
    logic              rr_ptr;       // 0: req0 wins next contention
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  cnt_rs1;
    logic [CNT_W-1:0]  cnt_rs2;
    logic [CNT_W-1:0]  cnt_alloc;
    logic              alloc_acc;
    logic              byp1;
    logic              byp2;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    // Arbitration
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !rr_ptr);
        grant1 = req1_valid && (!req0_valid ||  rr_ptr);
        sel_rd   = grant1 ? req1_rd   : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Counter lookups; indices beyond NREG read as idle
    always_comb begin
        cnt_rs1   = (int'(rs1)      < NREG) ? cnt[rs1]      : '0;
        cnt_rs2   = (int'(rs2)      < NREG) ? cnt[rs2]      : '0;
        cnt_alloc = (int'(alloc_rd) < NREG) ? cnt[alloc_rd] : '0;
    end

    // A saturated counter can still take an alloc when a commit to the same
    // register frees a slot this cycle (net change zero).
    always_comb begin
        alloc_ready = (alloc_rd == '0) || (cnt_alloc != CNT_MAX) ||
                      (rf_we && (rf_rd == alloc_rd));
        alloc_acc   = alloc_valid && alloc_ready && (alloc_rd != '0);
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            inc_vec[r] = alloc_acc && (alloc_rd == ADDR_W'(r));
            // commit to an idle counter is a protocol error: hold at zero
            dec_vec[r] = rf_we && (rf_rd == ADDR_W'(r)) && (cnt[r] != '0);
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        byp1 = rf_we && (rs1 != '0) && (rf_rd == rs1) && (cnt_rs1 == CNT_ONE) &&
               !(alloc_acc && (alloc_rd == rs1));
        byp2 = rf_we && (rs2 != '0) && (rf_rd == rs2) && (cnt_rs2 == CNT_ONE) &&
               !(alloc_acc && (alloc_rd == rs2));
        fwd1_valid = byp1;
        fwd1_data  = byp1 ? rf_wdata : '0;
        fwd2_valid = byp2;
        fwd2_data  = byp2 ? rf_wdata : '0;
    end
`else
    always_comb begin
        byp1       = 1'b0;
        byp2       = 1'b0;
        fwd1_valid = 1'b0;
        fwd1_data  = '0;
        fwd2_valid = 1'b0;
        fwd2_data  = '0;
    end
`endif

    always_comb begin
        stall = ((rs1 != '0) && (cnt_rs1 != '0) && !byp1) ||
                ((rs2 != '0) && (cnt_rs2 != '0) && !byp2);
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            rf_we <= (grant0 || grant1) && (sel_rd != '0);
            if (grant0 || grant1) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
            if (req0_valid && req1_valid) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    // Pending-write counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mcnt [32];     // outstanding writes per register
    bit          m_we;          // write expected on the port this cycle
    int          m_rd;
    logic [31:0] m_wdata;
    int          next_win;      // requester that wins the next contention

    function automatic bit exp_g0();
        return req0_valid && (!req1_valid || next_win == 0);
    endfunction

    function automatic bit exp_g1();
        return req1_valid && (!req0_valid || next_win == 1);
    endfunction

    function automatic bit exp_aready();
        if (alloc_rd == 0) return 1'b1;
        if (mcnt[alloc_rd] < 3) return 1'b1;
        return m_we && (m_rd == int'(alloc_rd));
    endfunction

    function automatic bit exp_byp(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        bit same_alloc;
        same_alloc = alloc_valid && exp_aready() && (alloc_rd == rs);
        return (rs != 0) && m_we && (m_rd == int'(rs)) && (mcnt[rs] == 1) && !same_alloc;
`else
        return rs != rs;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            m_we     = 1'b0;
            m_rd     = 0;
            m_wdata  = '0;
            next_win = 0;
        end else begin
            bit g0, g1, acc;
            g0  = exp_g0();
            g1  = exp_g1();
            acc = alloc_valid && exp_aready() && (alloc_rd != 0);
            if (acc) mcnt[alloc_rd] = mcnt[alloc_rd] + 1;
            if (m_we && mcnt[m_rd] > 0) mcnt[m_rd] = mcnt[m_rd] - 1;
            if (req0_valid && req1_valid) next_win = g0 ? 1 : 0;
            if (g0) begin
                m_we = (req0_rd != 0); m_rd = req0_rd; m_wdata = req0_data;
            end else if (g1) begin
                m_we = (req1_rd != 0); m_rd = req1_rd; m_wdata = req1_data;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit b1, b2, es;
        b1 = exp_byp(rs1);
        b2 = exp_byp(rs2);
        es = ((rs1 != 0) && (mcnt[rs1] > 0) && !b1) || ((rs2 != 0) && (mcnt[rs2] > 0) && !b2);
        chk("m_req0_ready", req0_ready, exp_g0());
        chk("m_req1_ready", req1_ready, exp_g1());
        chk("m_alloc_ready", alloc_ready, exp_aready());
        chk("m_stall", stall, es);
        chk("m_fwd1_valid", fwd1_valid, b1);
        chk("m_fwd1_data", fwd1_data, b1 ? m_wdata : 32'h0);
        chk("m_fwd2_valid", fwd2_valid, b2);
        chk("m_fwd2_data", fwd2_data, b2 ? m_wdata : 32'h0);
        chk("m_rf_we", rf_we, m_we);
        if (m_we) begin
            chk("m_rf_rd", rf_rd, m_rd);
            chk("m_rf_wdata", rf_wdata, m_wdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        alloc_valid = 0; alloc_rd = 0;
        rs1 = 0; rs2 = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        rs1 = 5;
        #12;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_stall", stall, 0);
        #5 rst_n = 1'b1;
        tick();

        // single requester: alloc r5, write r5 next cycle
        alloc_valid = 1; alloc_rd = 5; rs1 = 5;
        #1 chk("single_alloc_ready", alloc_ready, 1);
        tick();
        alloc_valid = 0;
        req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
        #1 chk("single_req0_ready", req0_ready, 1);
        chk("single_stall_pending", stall, 1);
        tick();
        req0_valid = 0;
        #1 chk("single_rf_we", rf_we, 1);
        chk("single_rf_rd", rf_rd, 5);
        chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        chk("single_stall_commit", stall, 0);
`else
        chk("single_stall_commit", stall, 1);
`endif
        tick();
        #1 chk("single_stall_after", stall, 0);
        chk("single_we_pulse", rf_we, 0);
        rs1 = 0;

        // contention: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1; req0_rd = 5'(1 + k);  req0_data = 32'hA0000000 + k;
            req1_valid = 1; req1_rd = 5'(11 + k); req1_data = 32'hB0000000 + k;
            #1 chk("cont_req0_ready", req0_ready, (k % 2) == 0);
            chk("cont_req1_ready", req1_ready, (k % 2) == 1);
            tick();
            #1 chk("cont_rf_we", rf_we, 1);
            chk("cont_rf_rd", rf_rd, (k % 2 == 0) ? 1 + k : 11 + k);
            chk("cont_rf_wdata", rf_wdata, (k % 2 == 0) ? 32'hA0000000 + k : 32'hB0000000 + k);
        end
        idle_inputs();
        tick();
        rs1 = 1; rs2 = 12;
        #1 chk("cont_no_wrap_stall", stall, 0);

        // x0 handling
        idle_inputs();
        req1_valid = 1; req1_rd = 0; req1_data = 32'h55;
        #1 chk("x0_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        alloc_valid = 1; alloc_rd = 0; rs1 = 0;
        #1 chk("x0_rf_we", rf_we, 0);
        chk("x0_alloc_ready", alloc_ready, 1);
        tick();
        alloc_valid = 0;
        #1 chk("x0_stall", stall, 0);

        // saturation on r7
        alloc_valid = 1; alloc_rd = 7;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sat_alloc_ready", alloc_ready, 1);
            tick();
        end
        req0_valid = 1; req0_rd = 7; req0_data = 32'h77;
        #1 chk("sat_alloc_full", alloc_ready, 0);
        tick();
        req0_valid = 0;
        #1 chk("sat_commit_we", rf_we, 1);
        chk("sat_alloc_with_commit", alloc_ready, 1);
        tick();
        #1 chk("sat_still_full", alloc_ready, 0);
        alloc_valid = 0;
        tick();

        // bypass on r9 via rs2
        alloc_valid = 1; alloc_rd = 9;
        tick();
        alloc_valid = 0;
        req0_valid = 1; req0_rd = 9; req0_data = 32'h12345678;
        tick();
        req0_valid = 0; rs1 = 0; rs2 = 9;
        #1 chk("byp_rf_rd", rf_rd, 9);
`ifdef WB_BYPASS_EN
        chk("byp_stall", stall, 0);
        chk("byp_fwd2_valid", fwd2_valid, 1);
        chk("byp_fwd2_data", fwd2_data, 32'h12345678);
`else
        chk("byp_stall", stall, 1);
        chk("byp_fwd2_valid", fwd2_valid, 0);
        chk("byp_fwd2_data", fwd2_data, 0);
`endif
        tick();
        rs2 = 0;

        // asynchronous reset mid-stream with an accepted write in flight
        alloc_valid = 1; alloc_rd = 3;
        tick();
        alloc_valid = 0;
        req0_valid = 1; req0_rd = 3; req0_data = 32'hCAFE0003;
        tick();
        rs1 = 3; rs2 = 7;
        #1 chk("mid_pre_rf_we", rf_we, 1);
        chk("mid_pre_stall", stall, 1);
        rst_n = 1'b0;
        #1 chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rf_rd", rf_rd, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1 chk("post_rst_rf_we", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
